// File: rtl/psram_responder.sv
// QPI PSRAM stand-in backed by block RAM, oversampling the controller's SCLK.
// Answers quad write (0x38) and quad fast read (0xEB); other commands are ignored.
module psram_responder #(
    parameter int         ADDR_BITS   = 16,
    parameter int         WAIT_CYCLES = 6,
    parameter logic [7:0] INIT_VALUE  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_psram_cs,
    input  logic       i_psram_sclk,
    input  logic [3:0] i_psram_data,
    output logic [3:0] o_psram_data,
    output logic       o_psram_oe,
    output logic       o_busy,
    output logic [7:0] o_cmd
);

    localparam int         DEPTH     = 1 << ADDR_BITS;
    localparam logic [7:0] CMD_WRITE = 8'h38;
    localparam logic [7:0] CMD_READ  = 8'hEB;
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WAIT, S_READ, S_WRITE, S_IGNORE
    } state_t;

    state_t                 state;
    logic                   cs_q;
    logic                   sclk_q;
    logic                   sclk_p;
    logic [3:0]             data_q;
    logic [2:0]             nib_cnt;
    logic [7:0]             wait_cnt;
    logic [ADDR_BITS-1:0]   addr;
    logic                   phase;
    logic [3:0]             hold;
    logic [7:0]             rd_q;
    logic [7:0]             rd_byte;
    logic [7:0]             cmd_byte;
    logic                   rise;
    logic                   fall;
    logic                   we;

    // Stored as data ^ INIT_VALUE so a zeroed power-up image reads as INIT_VALUE.
    logic [7:0] mem [DEPTH];

    assign rise     = sclk_q & ~sclk_p;
    assign fall     = ~sclk_q & sclk_p;
    assign cmd_byte = {hold, data_q};
    assign rd_byte  = rd_q ^ INIT_VALUE;
    assign we       = (state == S_WRITE) & rise & phase & ~cs_q & ~reset;
    assign o_busy   = ~cs_q & (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= {hold, data_q} ^ INIT_VALUE;
        end
        rd_q <= mem[addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q         <= 1'b1;
            sclk_q       <= 1'b0;
            sclk_p       <= 1'b0;
            data_q       <= 4'h0;
            state        <= S_IDLE;
            nib_cnt      <= 3'd0;
            wait_cnt     <= 8'd0;
            addr         <= '0;
            phase        <= 1'b0;
            hold         <= 4'h0;
            o_psram_oe   <= 1'b0;
            o_psram_data <= 4'h0;
            o_cmd        <= 8'h00;
        end else begin
            cs_q   <= i_psram_cs;
            sclk_q <= i_psram_sclk;
            sclk_p <= sclk_q;
            data_q <= i_psram_data;
            if (cs_q) begin
                state      <= S_IDLE;
                o_psram_oe <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        state   <= S_CMD;
                        nib_cnt <= 3'd0;
                    end
                    S_CMD: if (rise) begin
                        hold    <= data_q;
                        nib_cnt <= nib_cnt + 3'd1;
                        if (nib_cnt[0]) begin
                            o_cmd   <= cmd_byte;
                            nib_cnt <= 3'd0;
                            addr    <= '0;
                            if (cmd_byte == CMD_WRITE || cmd_byte == CMD_READ)
                                state <= S_ADDR;
                            else
                                state <= S_IGNORE;
                        end
                    end
                    S_ADDR: if (rise) begin
                        // Shifting out the top keeps only the stored address bits.
                        addr    <= {addr[ADDR_BITS-5:0], data_q};
                        nib_cnt <= nib_cnt + 3'd1;
                        if (nib_cnt == 3'd5) begin
                            phase    <= 1'b0;
                            wait_cnt <= 8'd0;
                            if (o_cmd == CMD_WRITE)
                                state <= S_WRITE;
                            else if (WAIT_CYCLES == 0)
                                state <= S_READ;
                            else
                                state <= S_WAIT;
                        end
                    end
                    S_WAIT: if (rise) begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST)
                            state <= S_READ;
                    end
                    S_READ: if (fall) begin
                        o_psram_oe <= 1'b1;
                        phase      <= ~phase;
                        if (!phase) begin
                            o_psram_data <= rd_byte[7:4];
                            hold         <= rd_byte[3:0];
                        end else begin
                            o_psram_data <= hold;
                            addr         <= addr + 1'b1;
                        end
                    end
                    S_WRITE: if (rise) begin
                        phase <= ~phase;
                        if (!phase)
                            hold <= data_q;
                        else
                            addr <= addr + 1'b1;
                    end
                    S_IGNORE: o_psram_oe <= 1'b0;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_responder.sv
// Randomized scoreboard bench for psram_responder acting as the QPI controller.
// Read nibbles are checked by a monitor on SCLK rising edges against a byte-array model.
module tb_psram_responder;

    localparam int AB = 16;
    localparam int WC = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       sclk;
    logic [3:0] din;
    logic [3:0] dout;
    logic       oe;
    logic       busy;
    logic [7:0] cmd;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] model_mem [1 << AB];
    logic [3:0] exp_q [$];
    logic [7:0] wbuf [$];

    always #5 clk = ~clk;

    psram_responder #(
        .ADDR_BITS  (AB),
        .WAIT_CYCLES(WC),
        .INIT_VALUE (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_psram_cs  (cs),
        .i_psram_sclk(sclk),
        .i_psram_data(din),
        .o_psram_data(dout),
        .o_psram_oe  (oe),
        .o_busy      (busy),
        .o_cmd       (cmd)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the controller samples read data on SCLK rising edges.
    always @(posedge sclk) begin
        if (oe === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_oe: got nibble %0h expected none", dout);
            end else begin
                check("read_nibble", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cyc(input logic [3:0] d);
        @(negedge clk);
        sclk = 1'b0;
        din  = d;
        tick(1);
        @(negedge clk);
        sclk = 1'b1;
        tick(1);
    endtask

    task automatic begin_xfer;
        @(negedge clk);
        cs = 1'b0;
        tick(2);
    endtask

    task automatic end_xfer;
        @(negedge clk);
        sclk = 1'b0;
        tick(2);
        cs = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        cyc(b[7:4]);
        cyc(b[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) cyc(a[i*4 +: 4]);
    endtask

    task automatic do_write(input logic [23:0] a, input bit odd);
        logic [AB-1:0] idx;
        idx = a[AB-1:0];
        begin_xfer;
        send_byte(8'h38);
        send_addr(a);
        foreach (wbuf[i]) begin
            send_byte(wbuf[i]);
            model_mem[idx] = wbuf[i];
            idx++;
        end
        if (odd) cyc(4'($urandom));
        end_xfer;
        wbuf.delete();
    endtask

    task automatic push_expected(input logic [23:0] a, input int n);
        logic [AB-1:0] idx;
        idx = a[AB-1:0];
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model_mem[idx][7:4]);
            exp_q.push_back(model_mem[idx][3:0]);
            idx++;
        end
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        push_expected(a, n);
        begin_xfer;
        send_byte(8'hEB);
        send_addr(a);
        repeat (WC) cyc(4'($urandom));
        repeat (2 * n) cyc(4'($urandom));
        end_xfer;
        check("read_cmd", 32'(cmd), 32'h000000EB);
        check("read_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a;
        logic [23:0] last_a;
        int          n;
        int          kind;

        for (int i = 0; i < (1 << AB); i++) model_mem[i] = 8'h00;
        reset = 1'b1;
        cs    = 1'b1;
        sclk  = 1'b0;
        din   = 4'h0;
        tick(3);
        check("reset_oe", 32'(oe), 32'd0);
        check("reset_data", 32'(dout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cmd", 32'(cmd), 32'd0);
        reset = 1'b0;
        tick(2);

        // Write then read back one byte.
        wbuf = '{8'h79};
        do_write(24'h00C000, 1'b0);
        do_read(24'h00C000, 1);

        // Burst across the top of the address space.
        wbuf = '{8'hAA, 8'hBB, 8'hCC};
        do_write(24'h00FFFF, 1'b0);
        do_read(24'h00FFFF, 3);
        do_read(24'h000000, 1);

        // Abort during the address phase.
        begin_xfer;
        send_byte(8'h38);
        cyc(4'h0);
        cyc(4'h0);
        cyc(4'h3);
        @(negedge clk);
        sclk = 1'b0;
        tick(1);
        cs = 1'b1;
        tick(2);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_oe", 32'(oe), 32'd0);
        tick(2);
        do_read(24'h003000, 1);

        // Unknown command is ignored until deselect.
        begin_xfer;
        send_byte(8'h9F);
        tick(1);
        check("ignore_cmd", 32'(cmd), 32'h9F);
        check("ignore_busy", 32'(busy), 32'd1);
        repeat (8) begin
            cyc(4'hF);
            check("ignore_oe", 32'(oe), 32'd0);
        end
        check("ignore_busy_end", 32'(busy), 32'd1);
        end_xfer;
        check("ignore_idle", 32'(busy), 32'd0);
        do_read(24'h00C000, 1);

        // Lone trailing nibble is dropped.
        wbuf = '{8'h12};
        do_write(24'h000010, 1'b1);
        do_read(24'h000010, 2);

        // Reset in the middle of a read burst.
        push_expected(24'h00C000, 1);
        begin_xfer;
        send_byte(8'hEB);
        send_addr(24'h00C000);
        repeat (WC) cyc(4'h0);
        repeat (2) cyc(4'h0);
        @(negedge clk);
        sclk = 1'b0;
        tick(1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_oe", 32'(oe), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_cmd", 32'(cmd), 32'd0);
        reset = 1'b0;
        cs    = 1'b1;
        tick(4);
        check("midreset_drained", 32'(exp_q.size()), 32'd0);
        do_read(24'h00C000, 1);

        // Randomized mix of bursts, with discarded upper address bits.
        last_a = 24'h00C000;
        repeat (24) begin
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 4);
            a[23:16] = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                a[15:0] = 16'hFFFE + 16'($urandom_range(0, 1));
            else
                a[15:0] = 16'($urandom);
            if (kind == 0) begin
                repeat (n) wbuf.push_back(8'($urandom));
                do_write(a, $urandom_range(0, 3) == 0);
                last_a = a;
            end else if (kind == 1) begin
                do_read(last_a, n);
            end else begin
                do_read(a, n);
            end
        end

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/psram_responder.md
Name: psram_responder

Overview:
- Synthesizable QPI PSRAM stand-in that answers the serial protocol driven by the memory controller on the PSRAM pins: CS, SCLK and a 4-bit data bus.
- Backed by internal block RAM. Used in place of the external PSRAM for on-FPGA bring-up and in simulation, so the memory controller can be closed out against a deterministic device.
- Oversamples the controller's SCLK with the system clock. No second clock domain exists inside the block.

Parameters:
- ADDR_BITS, 16, number of byte-address bits actually stored; memory depth is 2^ADDR_BITS bytes.
- WAIT_CYCLES, 6, SCLK cycles between the last address nibble and the first read-data nibble for command 0xEB.
- INIT_VALUE, 8'h00, value every byte holds after configuration. Reset does not clear memory.

Ports:
- clk  input  1  system clock; must be at least 4x the SCLK frequency.
- reset  input  1  synchronous, active-high reset.
- i_psram_cs  input  1  chip select from the controller, active low.
- i_psram_sclk  input  1  serial clock from the controller, sampled as data.
- i_psram_data  input  4  nibble bus, controller to device.
- o_psram_data  output  4  nibble bus, device to controller.
- o_psram_oe  output  1  high while this block drives o_psram_data.
- o_busy  output  1  high whenever CS is low and the state is not IDLE.
- o_cmd  output  8  last command byte received (debug).

Behaviour:
- Input capture: cs, sclk and data are registered once per clk. Edge detection compares the registered sclk with its previous value.
  - SCLK rising edge = sample point.
  - SCLK falling edge = drive-update point.
- Reset values:
  - State = IDLE.
  - o_psram_oe = 0, o_psram_data = 4'h0, o_busy = 0, o_cmd = 8'h00.
  - Address and counters = 0.
  - Memory contents are preserved.
- Deselect: registered CS high forces IDLE from any state on the next clk and sets oe = 0. This is a synchronous abort; no partial write-back is pending.
- Nibble order everywhere is high nibble first.
- States:
  - IDLE: waits for CS low, then goes to CMD with nibble counter = 0.
  - CMD: 2 rising edges assemble the command byte.
    - 0x38 (quad write) goes to ADDR.
    - 0xEB (quad fast read) goes to ADDR.
    - Any other value goes to IGNORE.
    - o_cmd is updated with the assembled byte.
  - ADDR: 6 rising edges assemble a 24-bit address. Bits above ADDR_BITS are discarded.
    - After the sixth nibble: write command goes to WRITE; read command goes to WAIT with wait counter = 0.
  - WAIT: counts WAIT_CYCLES rising edges, then goes to READ.
    - On the falling edge that follows the last wait rising edge: oe = 1 and the high nibble of mem[addr] is driven.
    - WAIT_CYCLES = 0 is legal: the first read nibble is driven on the falling edge after the last address nibble.
  - READ: each falling edge drives the next nibble, alternating high and low.
    - After the low nibble, addr = addr + 1 modulo 2^ADDR_BITS and the next byte's high nibble follows.
    - The burst continues until CS goes high.
    - The data driven for a byte is fixed when that byte's high nibble is driven; it is not re-read mid-byte.
  - WRITE: each rising edge captures a nibble. The second nibble commits the byte to mem[addr] in the same clk, then addr increments modulo 2^ADDR_BITS.
    - A lone high nibble left when CS rises is discarded.
  - IGNORE: oe = 0, no memory access, stays until CS high.
- Simultaneous events:
  - CS rising in the same clk as an SCLK edge: deselect wins and the edge is ignored.
  - Reset asserted mid-burst: the transfer is abandoned and bytes already committed remain.
- Address wrap: 2^ADDR_BITS - 1 rolls over to 0 in both read and write bursts.
- Latency: a memory read completes within 2 clk of the address becoming known, which is guaranteed by the 4x oversampling ratio.

Test Plan:
- Write then read: write 0x38 to address 0x00C000 with data 0x79, deselect, then issue 0xEB to 0x00C000 → after 6 wait SCLKs, nibbles 7 then 9 are driven with oe = 1; o_cmd = 0xEB.
- Burst with wrap (ADDR_BITS=16): write 0xAA, 0xBB, 0xCC starting at 0x00FFFF → mem[0xFFFF] = 0xAA, mem[0x0000] = 0xBB, mem[0x0001] = 0xCC. A read burst from 0x00FFFF returns A,A,B,B,C,C.
- Abort in ADDR: CS goes high after 3 address nibbles of a write → state returns to IDLE within 2 clk and memory is unchanged. A following full read of the same address returns INIT_VALUE.
- Unknown command: send 0x9F, then 8 SCLKs with data 0xF → oe stays 0, memory is unchanged, o_cmd = 0x9F, o_busy = 1 until CS high.
- Odd nibble: write command, address 0x000010, then 3 data nibbles 1,2,3 and deselect → mem[0x10] = 0x12 and mem[0x11] is unchanged.
- Reset mid-read: assert reset during READ → oe = 0, o_busy = 0, o_cmd = 0x00 on the next clk. Memory written before the reset is still read back correctly afterwards.
